// File: rtl/distortion_mc_pkg.sv
// -----------------------------------------------------------------------------
// distortion_pkg
// Shared types and helpers for the multi-channel distortion stage.
//   mode_e      : per-sample clipping curve selector
//   Q88_UNITY   : 1.0 in the unsigned Q8.8 gain/boost format
//   stage_t     : pipeline record that travels with each sample
//   sat_w()     : clamp a wide signed value into a w-bit signed range
// The DIST_* constants size stage_t; the top-level parameters default to them
// and must be kept equal to them.
// -----------------------------------------------------------------------------
package distortion_pkg;

  localparam int DIST_DATA_W   = 24;
  localparam int DIST_CHANNELS = 2;
  localparam int DIST_GAIN_W   = 16;
  localparam int DIST_CH_W     = (DIST_CHANNELS > 1) ? $clog2(DIST_CHANNELS) : 1;

  localparam logic [DIST_GAIN_W-1:0] Q88_UNITY = 16'h0100;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_HARD   = 2'd1,
    MODE_SOFT   = 2'd2,
    MODE_ASYM   = 2'd3
  } mode_e;

  // Everything a sample needs downstream of acceptance, so that configuration
  // changes only ever affect later samples.
  typedef struct packed {
    logic                          valid;
    logic [DIST_CH_W-1:0]          channel;
    logic signed [DIST_DATA_W-1:0] data;   // raw input when byp, else working value
    mode_e                         mode;
    logic [DIST_GAIN_W-1:0]        boost;
    logic [DIST_DATA_W-1:0]        clip;   // magnitude, MSB already cleared
    logic                          byp;
  } stage_t;

  // Saturate v to [-2^(w-1), 2^(w-1)-1]; callers size-cast the result to w.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v,
                                               input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

endpackage

// File: rtl/distortion_mc_if.sv
// -----------------------------------------------------------------------------
// distortion_mc_if
// Valid/ready sample stream carrying a channel tag.
//   valid   : producer has a sample
//   ready   : consumer accepts the sample this cycle
//   channel : channel the sample belongs to
//   data    : signed Q1.(DATA_W-1) sample
// master drives the stream, slave consumes it.
// -----------------------------------------------------------------------------
interface distortion_mc_if #(
  parameter int DATA_W = 24,
  parameter int CH_W   = 1
);
  logic                     valid;
  logic                     ready;
  logic [CH_W-1:0]          channel;
  logic signed [DATA_W-1:0] data;

  modport master (output valid, output channel, output data, input ready);
  modport slave  (input valid, input channel, input data, output ready);
endinterface

// File: rtl/distortion_mc_soft_clip.sv
// -----------------------------------------------------------------------------
// dist_soft_clip
// Two-stage squaring/cubing datapath producing the cubic soft clip
// s = sat(1.5u - 0.5u^3) for a signed Q1.(DATA_W-1) input.
//   clk, aclr : clock, asynchronous active-high reset
//   i_en      : pipeline advance; both stages hold when low
//   i_u       : pre-gained sample
//   o_s       : soft-clipped result, two enabled cycles after i_u
// -----------------------------------------------------------------------------
module dist_soft_clip
  import distortion_pkg::*;
#(
  parameter int DATA_W = 24
) (
  input  logic                     clk,
  input  logic                     aclr,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_u,
  output logic signed [DATA_W-1:0] o_s
);

  logic signed [DATA_W-1:0] r_u;
  // u*u for u = -1.0 is exactly +1.0, one bit beyond the sample range.
  logic signed [DATA_W:0]   r_sq;
  logic signed [DATA_W-1:0] r_s;

  logic signed [63:0]       w_u_ext;
  logic signed [DATA_W:0]   w_sq;
  logic signed [63:0]       w_cu;
  logic signed [63:0]       w_sum;
  logic signed [DATA_W-1:0] w_s;

  assign w_u_ext = 64'(i_u);
  assign w_sq    = (DATA_W + 1)'((w_u_ext * w_u_ext) >>> (DATA_W - 1));

  assign w_cu  = (64'(r_sq) * 64'(r_u)) >>> (DATA_W - 1);
  assign w_sum = 64'(r_u) + (64'(r_u) >>> 1) - (w_cu >>> 1);
  assign w_s   = DATA_W'(sat_w(w_sum, DATA_W));

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_u  <= '0;
      r_sq <= '0;
      r_s  <= '0;
    end else if (i_en) begin
      r_u  <= i_u;
      r_sq <= w_sq;
      r_s  <= w_s;
    end
  end

  assign o_s = r_s;

endmodule

// File: rtl/distortion_mc.sv
// -----------------------------------------------------------------------------
// distortion_mc
// Time-multiplexed fixed-point distortion: pre-gain, selectable clip curve
// (hard / cubic soft / asymmetric), post-boost. Fixed 4-cycle pipeline with
// whole-pipe stall under backpressure.
//   clk, aclr    : clock, asynchronous active-high reset
//   s_in         : input stream (slave)  - tagged samples from the deserialiser
//   m_out        : output stream (master) - processed tagged samples
//   mode         : 0 bypass, 1 hard, 2 soft, 3 asymmetric
//   gain, boost  : pre-/post-gain, unsigned Q8.8
//   clip_level   : hard-clip magnitude, MSB ignored
//   bypass_mask  : per-channel forced bypass
// Pipeline: S1 gain -> S2 square / hard clip -> S3 cube / soft clip ->
//           S4 curve select + boost into the output register.
// -----------------------------------------------------------------------------
module distortion_mc
  import distortion_pkg::*;
#(
  parameter int DATA_W   = DIST_DATA_W,
  parameter int CHANNELS = DIST_CHANNELS,
  parameter int GAIN_W   = DIST_GAIN_W,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                aclr,
  distortion_mc_if.slave      s_in,
  distortion_mc_if.master     m_out,
  input  logic [1:0]          mode,
  input  logic [GAIN_W-1:0]   gain,
  input  logic [GAIN_W-1:0]   boost,
  input  logic [DATA_W-1:0]   clip_level,
  input  logic [CHANNELS-1:0] bypass_mask
);

  stage_t                   r_s1;
  stage_t                   r_s2;
  stage_t                   r_s3;
  logic signed [DATA_W-1:0] r_h2;
  logic signed [DATA_W-1:0] r_h3;
  logic                     r_out_valid;
  logic [CH_W-1:0]          r_out_channel;
  logic signed [DATA_W-1:0] r_out_data;

  logic                     w_advance;
  logic                     w_accept;
  logic                     w_byp_in;
  logic signed [DATA_W-1:0] w_u;
  stage_t                   w_s1_next;
  logic signed [DATA_W-1:0] w_u1;
  logic signed [DATA_W-1:0] w_clip1;
  logic signed [DATA_W-1:0] w_h;
  logic signed [DATA_W-1:0] w_soft;
  logic signed [DATA_W-1:0] w_u3;
  logic signed [DATA_W-1:0] w_clip3;
  logic signed [DATA_W-1:0] w_y;
  logic signed [DATA_W-1:0] w_boosted;

  // ---------------------------------------------------------------- handshake
  // Every stage moves together; a stalled output freezes bubbles too.
  assign w_advance  = !r_out_valid || m_out.ready;
  assign s_in.ready = w_advance && !aclr;
  assign w_accept   = s_in.valid && s_in.ready;

  // ------------------------------------------------------------ S1: pre-gain
  assign w_byp_in = (mode_e'(mode) == MODE_BYPASS) || bypass_mask[s_in.channel];
  assign w_u      = DATA_W'(sat_w((64'(s_in.data) * $signed(64'(gain))) >>> 8, DATA_W));

  always_comb begin
    w_s1_next         = '0;
    w_s1_next.valid   = w_accept;
    w_s1_next.channel = s_in.channel;
    // Bypassed samples carry the raw input so they emerge bit-exact.
    w_s1_next.data    = w_byp_in ? s_in.data : w_u;
    w_s1_next.mode    = mode_e'(mode);
    w_s1_next.boost   = boost;
    w_s1_next.clip    = clip_level & {1'b0, {(DATA_W-1){1'b1}}};
    w_s1_next.byp     = w_byp_in;
  end

  // ---------------------------------------------------------- S2: hard clip
  assign w_u1    = $signed(r_s1.data);
  assign w_clip1 = $signed(r_s1.clip);

  always_comb begin
    if (w_u1 > w_clip1)
      w_h = w_clip1;
    else if (w_u1 < -w_clip1)
      w_h = -w_clip1;
    else
      w_h = w_u1;
  end

  // ------------------------------------------------------ S2-S3: soft clip
  // Its two registers line up with r_s2 and r_s3.
  dist_soft_clip #(
    .DATA_W (DATA_W)
  ) u_soft (
    .clk  (clk),
    .aclr (aclr),
    .i_en (w_advance),
    .i_u  (w_u1),
    .o_s  (w_soft)
  );

  // ------------------------------------------------ S4: select and boost
  assign w_u3    = $signed(r_s3.data);
  assign w_clip3 = $signed(r_s3.clip);

  always_comb begin
    w_y = w_u3;
    case (r_s3.mode)
      MODE_HARD: w_y = r_h3;
      MODE_SOFT: w_y = w_soft;
      MODE_ASYM: begin
        // Soft on the positive half, one-sided floor on the negative half.
        if (w_u3 >= 0)
          w_y = w_soft;
        else if (w_u3 < -w_clip3)
          w_y = -w_clip3;
        else
          w_y = w_u3;
      end
      default: w_y = w_u3;
    endcase
  end

  assign w_boosted = DATA_W'(sat_w((64'(w_y) * $signed(64'(r_s3.boost))) >>> 8, DATA_W));

  // ------------------------------------------------------------- registers
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_s1          <= '0;
      r_s2          <= '0;
      r_s3          <= '0;
      r_h2          <= '0;
      r_h3          <= '0;
      r_out_valid   <= 1'b0;
      r_out_channel <= '0;
      r_out_data    <= '0;
    end else if (w_advance) begin
      r_s1        <= w_s1_next;
      r_s2        <= r_s1;
      r_h2        <= w_h;
      r_s3        <= r_s2;
      r_h3        <= r_h2;
      r_out_valid <= r_s3.valid;
      if (r_s3.valid) begin
        r_out_channel <= r_s3.channel;
        r_out_data    <= r_s3.byp ? w_u3 : w_boosted;
      end
    end
  end

  assign m_out.valid   = r_out_valid;
  assign m_out.channel = r_out_channel;
  assign m_out.data    = r_out_data;

endmodule

// File: tb/tb_distortion_mc.sv
// -----------------------------------------------------------------------------
// tb_distortion_mc
// Scoreboard bench: the driver pushes expected (channel, data) on acceptance,
// an independent monitor compares whenever the DUT shows a valid output.
// -----------------------------------------------------------------------------
module tb_distortion_mc;

  localparam int DW  = 24;
  localparam int CHN = 2;
  localparam int GW  = 16;
  localparam int CW  = 1;

  logic          clk = 1'b0;
  logic          aclr = 1'b1;
  logic [1:0]    mode = '0;
  logic [GW-1:0] gain = '0;
  logic [GW-1:0] boost = '0;
  logic [DW-1:0] clip_level = '0;
  logic [CHN-1:0] bypass_mask = '0;

  always #5 clk = ~clk;

  distortion_mc_if #(.DATA_W(DW), .CH_W(CW)) in_if ();
  distortion_mc_if #(.DATA_W(DW), .CH_W(CW)) out_if ();

  distortion_mc #(
    .DATA_W(DW), .CHANNELS(CHN), .GAIN_W(GW), .CH_W(CW)
  ) dut (
    .clk         (clk),
    .aclr        (aclr),
    .s_in        (in_if),
    .m_out       (out_if),
    .mode        (mode),
    .gain        (gain),
    .boost       (boost),
    .clip_level  (clip_level),
    .bypass_mask (bypass_mask)
  );

  typedef struct {
    logic [CW-1:0] ch;
    logic [DW-1:0] data;
    int            acc_cyc;
    bit            chk_lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------- reference model
  function automatic longint sat_ref(input longint v);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -(longint'(1) <<< (DW - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic [DW-1:0] ref_model(input logic [DW-1:0] din,
      input logic [CW-1:0] ch, input logic [1:0] md, input logic [GW-1:0] g,
      input logic [GW-1:0] b, input logic [DW-1:0] cl, input logic [CHN-1:0] mk);
    longint x, u, c, sq, cu, s, h, y, o;
    logic [DW-1:0] clm;
    logic [63:0]   ov;
    if (md == 2'd0 || mk[ch]) return din;
    x   = longint'($signed(din));
    u   = sat_ref((x * longint'(g)) >>> 8);
    clm = cl & 24'h7FFFFF;
    c   = longint'(clm);
    sq  = (u * u) >>> (DW - 1);
    cu  = (sq * u) >>> (DW - 1);
    s   = sat_ref(u + (u >>> 1) - (cu >>> 1));
    h   = (u > c) ? c : ((u < -c) ? -c : u);
    case (md)
      2'd1:    y = h;
      2'd2:    y = s;
      default: y = (u >= 0) ? s : ((u < -c) ? -c : u);
    endcase
    o  = sat_ref((y * longint'(b)) >>> 8);
    ov = o;
    return ov[DW-1:0];
  endfunction

  // ------------------------------------------------------------- monitor
  always @(negedge clk) begin
    exp_t e;
    logic exp_rdy;
    if (!aclr) begin
      exp_rdy = !(out_if.valid && !out_if.ready);
      tests++;
      if (in_if.ready !== exp_rdy) begin
        fails++;
        $display("FAIL in_ready: got %b expected %b (cyc %0d)", in_if.ready, exp_rdy, cyc);
      end
      if (out_if.valid) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: got ch%0d data %06h, none expected (cyc %0d)",
                   out_if.channel, out_if.data, cyc);
        end else begin
          e = sb[0];
          if (out_if.data !== e.data || out_if.channel !== e.ch) begin
            fails++;
            $display("FAIL out_sample: got ch%0d %06h expected ch%0d %06h (cyc %0d)",
                     out_if.channel, out_if.data, e.ch, e.data, cyc);
          end
          if (out_if.ready) begin
            void'(sb.pop_front());
            $display("[TB] out ch%0d data %06h (expected %06h) cyc %0d",
                     out_if.channel, out_if.data, e.data, cyc);
            if (e.chk_lat) begin
              tests++;
              if (cyc - e.acc_cyc != 4) begin
                fails++;
                $display("FAIL latency: got %0d cycles expected 4", cyc - e.acc_cyc);
              end
            end
          end
        end
      end
    end
  end

  // -------------------------------------------------------------- driver
  // Called just after a rising edge; returns just after a rising edge.
  task automatic send(input logic [CW-1:0] ch, input logic [DW-1:0] d,
      input logic [1:0] md, input logic [GW-1:0] g, input logic [GW-1:0] b,
      input logic [DW-1:0] cl, input logic [CHN-1:0] mk,
      input logic [DW-1:0] exp_d, input bit lat);
    exp_t e;
    int   waitc;
    waitc          = 0;
    in_if.channel  = ch;
    in_if.data     = d;
    mode           = md;
    gain           = g;
    boost          = b;
    clip_level     = cl;
    bypass_mask    = mk;
    in_if.valid    = 1'b1;
    forever begin
      @(negedge clk);
      if (in_if.ready) begin
        e.ch = ch; e.data = exp_d; e.acc_cyc = cyc; e.chk_lat = lat;
        sb.push_back(e);
        break;
      end
      waitc++;
      if (waitc > 200) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: in_ready never high within 200 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
  endtask

  task automatic send_rand(input bit lat);
    logic [CW-1:0]  ch;
    logic [DW-1:0]  d, cl;
    logic [1:0]     md;
    logic [GW-1:0]  g, b;
    logic [CHN-1:0] mk;
    ch = CW'($urandom_range(0, CHN - 1));
    d  = DW'($urandom);
    md = 2'($urandom_range(0, 3));
    g  = GW'($urandom_range(0, 16'h0600));
    b  = GW'($urandom_range(0, 16'h0300));
    cl = DW'($urandom);
    mk = CHN'($urandom_range(0, 3));
    send(ch, d, md, g, b, cl, mk, ref_model(d, ch, md, g, b, cl, mk), lat);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d samples outstanding expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check1(input string name, input logic [DW-1:0] got, input logic [DW-1:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %06h expected %06h", name, got, req);
    end
  endtask

  // ------------------------------------------------------------ watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ stimulus
  bit rnd_done;

  initial begin
    in_if.valid   = 1'b0;
    in_if.channel = '0;
    in_if.data    = '0;
    out_if.ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check1("reset_out_valid", DW'(out_if.valid), '0);
    check1("reset_in_ready", DW'(in_if.ready), '0);
    check1("reset_out_data", out_if.data, '0);
    check1("reset_out_channel", DW'(out_if.channel), '0);
    aclr = 1'b0;
    @(posedge clk);
    #1;

    // Directed curve and boundary cases, back to back with latency checks.
    send(0, 24'h200000, 2'd1, 16'h0400, 16'h0100, 24'h400000, 2'b00, 24'h400000, 1);
    send(0, 24'h200000, 2'd2, 16'h0200, 16'h0100, 24'h400000, 2'b00, 24'h580000, 1);
    send(1, 24'h7FFFFF, 2'd2, 16'h0100, 16'h0100, 24'h400000, 2'b00, 24'h7FFFFF, 1);
    send(0, 24'hC00000, 2'd2, 16'h0100, 16'h0100, 24'h400000, 2'b00, 24'hA80000, 1);
    send(0, 24'hC00000, 2'd3, 16'h0100, 16'h0200, 24'h200000, 2'b00, 24'hC00000, 1);
    send(1, 24'h400000, 2'd3, 16'h0100, 16'h0200, 24'h200000, 2'b00, 24'h7FFFFF, 1);
    send(0, 24'h300000, 2'd1, 16'h0100, 16'h0100, 24'h100000, 2'b10, 24'h100000, 1);
    send(1, 24'h300000, 2'd1, 16'h0100, 16'h0100, 24'h100000, 2'b10, 24'h300000, 1);
    send(0, 24'h123456, 2'd1, 16'h0100, 16'h0100, 24'h000000, 2'b00, 24'h000000, 1);
    send(1, 24'h600000, 2'd1, 16'h0100, 16'h0100, 24'hC00000, 2'b00, 24'h400000, 1);
    send(0, 24'h654321, 2'd2, 16'h0000, 16'h0100, 24'h400000, 2'b00, 24'h000000, 1);
    send(0, 24'h800000, 2'd2, Q1_0(), 16'h0100, 24'h400000, 2'b00, 24'h800000, 1);
    send(1, 24'h123456, 2'd0, 16'h0000, 16'h0000, 24'h000000, 2'b00, 24'h123456, 1);
    drain();

    // Backpressure: 8 samples with a 5-cycle downstream stall mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand(0);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_if.ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_if.ready = 1'b1;
      end
    join
    drain();

    // Reset with samples in flight: nothing stale may emerge afterwards.
    for (int i = 0; i < 5; i++) send_rand(0);
    aclr = 1'b1;
    #1;
    check1("aclr_out_valid", DW'(out_if.valid), '0);
    check1("aclr_in_ready", DW'(in_if.ready), '0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    aclr = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    send(1, 24'h200000, 2'd1, 16'h0400, 16'h0100, 24'h400000, 2'b00, 24'h400000, 1);
    drain();

    // Randomized stream with random downstream backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) send_rand(0);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_if.ready = ($urandom_range(0, 9) < 7);
        end
        out_if.ready = 1'b1;
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic logic [GW-1:0] Q1_0();
    return 16'h0100;
  endfunction

endmodule

// File: doc/distortion_mc.md
Name: distortion_mc

Overview:
Multi-channel, time-multiplexed fixed-point distortion stage for the effects chain, and the successor of the single-channel float distortion.
- Applies pre-gain, then a selectable clipping curve (hard, cubic soft, asymmetric), then post-boost to signed Q1.(DATA_W-1) samples.
- Uses a valid/ready handshake instead of a free-running sample counter.
- Fixed 4-cycle pipeline with backpressure; sits between the ADC deserialiser and the downstream effect blocks.

Parameters:
DATA_W, 24, sample width, signed Q1.(DATA_W-1); full scale ±1.0
CHANNELS, 2, number of interleaved channels
GAIN_W, 16, width of gain/boost words, unsigned Q8.8
CH_W, max(1,$clog2(CHANNELS)), channel index width (derived)

Ports:
clk  in  1  clock
aclr  in  1  reset, asynchronous, active-high
in_valid  in  1  input sample valid
in_ready  out  1  block accepts a sample this cycle
in_channel  in  CH_W  channel of input sample
in_data  in  DATA_W  input sample, signed
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts output
out_channel  out  CH_W  channel of output sample
out_data  out  DATA_W  processed sample, signed
mode  in  2  0 bypass, 1 hard clip, 2 cubic soft clip, 3 asymmetric
gain  in  GAIN_W  pre-gain, Q8.8 (0x0100 = 1.0)
boost  in  GAIN_W  post-gain, Q8.8
clip_level  in  DATA_W  positive hard-clip threshold, Q1.(DATA_W-1)
bypass_mask  in  CHANNELS  bit c set: channel c forced to bypass regardless of mode

Behaviour:
- Reset (aclr high, async): all stage valids 0, out_valid 0, out_data 0, out_channel 0, in_ready 0 while aclr is high.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance && !aclr.
  - Sample accepted when in_valid && in_ready. The output is held stable while out_valid && !out_ready.
  - The whole pipe stalls on advance=0, bubbles included.
- Latency: exactly 4 advancing cycles from acceptance to out_valid, in all modes including bypass. Order preserved; channel tag travels with the sample.
- Configuration capture:
  - mode, gain, boost, clip_level and bypass_mask[in_channel] are captured at acceptance and carried with the sample.
  - Changing them mid-stream affects only later-accepted samples.
- Saturation sat(v): clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. All right shifts are arithmetic (floor).
- S1: u = sat((in_data * gain) >>> 8).
- S2: sq = (u*u) >>> (DATA_W-1); hard clip h = clamp(u, -clip_level, clip_level).
- S3: cu = (sq*u) >>> (DATA_W-1); soft s = sat(u + (u>>>1) - (cu>>>1)), i.e. 1.5u - 0.5u^3.
- Curve selected per sample:
  - mode 1: h
  - mode 2: s
  - mode 3: s if u >= 0, else max(u, -clip_level)
- S4: out_data = sat((y * boost) >>> 8).
- Bypass (mode 0 or mask bit set): out_data = in_data bit-exact; gain and boost are ignored.
- Boundary cases:
  - clip_level = 0 gives out 0 in hard mode.
  - clip_level is treated as unsigned magnitude; its MSB is ignored.
  - gain = 0 gives 0.
  - in_data = most-negative value with gain 1.0 passes S1 unchanged.
- Reset mid-operation: in-flight samples are discarded with no output; the first sample after release has full 4-cycle latency.
- Simultaneous in_valid and out stall: not accepted. in_valid may be held; the sample is accepted on the first cycle with in_ready high.

Decomposition:
- Package distortion_pkg:
  - mode enum (MODE_BYPASS, MODE_HARD, MODE_SOFT, MODE_ASYM)
  - Q8.8 unity constant 0x0100
  - stage record type {valid, channel, data, mode, boost, clip, byp}
  - sat function parametrised by width
- One sub-module, dist_soft_clip: S2–S3 squaring/cubing datapath, 2-stage with enable, instantiated once.

Test Plan:
- Hard clip: mode=1, gain=0x0400, boost=0x0100, clip=0x400000, in=0x200000 -> out=0x400000 on ch0, 4 cycles after acceptance.
- Soft clip: mode=2, gain=0x0200, boost=0x0100, in=0x200000 -> out=0x580000; in=0x7FFFFF, gain=0x0100 -> out=0x7FFFFF (saturated); in=-0x400000 -> out=-0x580000.
- Asymmetric plus boost: mode=3, gain=0x0100, clip=0x200000, boost=0x0200; in=-0x400000 -> out=-0x400000; in=0x400000 -> out=0x7FFFFF.
- Per-channel bypass: CHANNELS=2, mask=2'b10, mode=1, interleaved ch0/ch1 in=0x300000, clip=0x100000 -> ch0 out=0x100000, ch1 out=0x300000, tags preserved in order.
- Backpressure: stream 8 samples, hold out_ready=0 for 5 cycles mid-stream -> in_ready drops, out_data/out_channel stable, no loss or duplication, order intact.
- Reset mid-stream: assert aclr with 3 samples in flight -> out_valid=0 immediately, no stale samples after release; next sample appears after exactly 4 cycles.
